// File: rtl/load_writeback_unit.sv
// load_writeback_unit: merges ALU results and load completions onto the
// register file write port. It aligns and extends load data, holds one
// outstanding load and one stalled ALU result, and flags RAW hazards on
// destinations that are still pending.
module load_writeback_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  output logic        alu_ready,
  input  logic        ld_req,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  output logic        ld_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hazard,
  output logic        write,
  output logic [4:0]  wrAddr,
  output logic [31:0] wrData
);

  typedef enum logic [0:0] {
    LD_IDLE = 1'b0,
    LD_WAIT = 1'b1
  } ld_state_t;

  ld_state_t   state_r;
  ld_state_t   state_nxt_s;

  logic [4:0]  ld_rd_r;
  logic [2:0]  ld_f3_r;
  logic [1:0]  ld_lo_r;

  logic        buf_valid_r;
  logic [4:0]  buf_rd_r;
  logic [31:0] buf_data_r;

  logic        ld_take_s;
  logic        ld_done_s;
  logic        ld_wr_s;
  logic        alu_take_s;
  logic        buf_fill_s;
  logic        buf_drain_s;
  logic        port_write_s;
  logic [4:0]  port_addr_s;
  logic [31:0] port_data_s;

  // Select the addressed byte/halfword of a little-endian word and extend it.
  // Any funct3 that is not a byte or halfword load is handled as LW.
  function automatic logic [31:0] load_align(input logic [2:0]  f3,
                                             input logic [1:0]  lo,
                                             input logic [31:0] raw);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (lo)
      2'd0:    byte_v = raw[7:0];
      2'd1:    byte_v = raw[15:8];
      2'd2:    byte_v = raw[23:16];
      2'd3:    byte_v = raw[31:24];
      default: byte_v = raw[7:0];
    endcase
    if (lo[1]) begin
      half_v = raw[31:16];
    end else begin
      half_v = raw[15:0];
    end
    case (f3)
      3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  res_v = {{16{half_v[15]}}, half_v};
      3'b100:  res_v = {24'h00_0000, byte_v};
      3'b101:  res_v = {16'h0000, half_v};
      default: res_v = raw;
    endcase
    return res_v;
  endfunction

  // A nonzero source matching a pending destination must stall decode.
  function automatic logic src_hit(input logic [4:0] rs,
                                   input logic       ld_pend,
                                   input logic [4:0] ld_dst,
                                   input logic       buf_pend,
                                   input logic [4:0] buf_dst,
                                   input logic       wr_pend,
                                   input logic [4:0] wr_dst);
    logic hit_v;
    if (rs == 5'd0) begin
      hit_v = 1'b0;
    end else begin
      hit_v = (ld_pend && (rs == ld_dst)) ||
              (buf_pend && (rs == buf_dst)) ||
              (wr_pend && (rs == wr_dst));
    end
    return hit_v;
  endfunction

  assign ld_ready  = (state_r == LD_IDLE);
  assign alu_ready = ~buf_valid_r;
  assign ld_take_s = (state_r == LD_IDLE) && ld_req;
  assign ld_done_s = (state_r == LD_WAIT) && mem_rvalid;
  // A load to x0 completes without claiming the write port.
  assign ld_wr_s   = ld_done_s && (ld_rd_r != 5'd0);
  // ALU results for x0 are discarded outright; full-buffer arrivals are dropped.
  assign alu_take_s  = alu_valid && ~buf_valid_r && (alu_rd != 5'd0);
  assign buf_fill_s  = alu_take_s && ld_wr_s;
  assign buf_drain_s = buf_valid_r && ~ld_wr_s;

  // Load FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= LD_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Load FSM next state: wait for memory after an accepted request.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LD_IDLE: begin
        if (ld_req) begin
          state_nxt_s = LD_WAIT;
        end else begin
          state_nxt_s = LD_IDLE;
        end
      end
      LD_WAIT: begin
        if (mem_rvalid) begin
          state_nxt_s = LD_IDLE;
        end else begin
          state_nxt_s = LD_WAIT;
        end
      end
      default: state_nxt_s = LD_IDLE;
    endcase
  end

  // Capture destination and access shape of the load when it is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_rd_r <= 5'd0;
      ld_f3_r <= 3'd0;
      ld_lo_r <= 2'd0;
    end else if (ld_take_s) begin
      ld_rd_r <= ld_rd;
      ld_f3_r <= ld_funct3;
      ld_lo_r <= ld_addr_lo;
    end else begin
      ld_rd_r <= ld_rd_r;
      ld_f3_r <= ld_f3_r;
      ld_lo_r <= ld_lo_r;
    end
  end

  // Write-port arbitration: load completion, then buffered ALU, then live ALU.
  always_comb begin
    port_write_s = 1'b0;
    port_addr_s  = wrAddr;
    port_data_s  = wrData;
    if (ld_wr_s) begin
      port_write_s = 1'b1;
      port_addr_s  = ld_rd_r;
      port_data_s  = load_align(ld_f3_r, ld_lo_r, mem_rdata);
    end else if (buf_valid_r) begin
      port_write_s = 1'b1;
      port_addr_s  = buf_rd_r;
      port_data_s  = buf_data_r;
    end else if (alu_take_s) begin
      port_write_s = 1'b1;
      port_addr_s  = alu_rd;
      port_data_s  = alu_result;
    end else begin
      port_write_s = 1'b0;
    end
  end

  // Stall buffer for an ALU result that lost arbitration to a load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid_r <= 1'b0;
      buf_rd_r    <= 5'd0;
      buf_data_r  <= 32'h0000_0000;
    end else if (buf_fill_s) begin
      buf_valid_r <= 1'b1;
      buf_rd_r    <= alu_rd;
      buf_data_r  <= alu_result;
    end else if (buf_drain_s) begin
      buf_valid_r <= 1'b0;
    end else begin
      buf_valid_r <= buf_valid_r;
    end
  end

  // Registered write port; address and data hold between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write  <= 1'b0;
      wrAddr <= 5'd0;
      wrData <= 32'h0000_0000;
    end else begin
      write <= port_write_s;
      if (port_write_s) begin
        wrAddr <= port_addr_s;
        wrData <= port_data_s;
      end else begin
        wrAddr <= wrAddr;
        wrData <= wrData;
      end
    end
  end

  // Hazard against the outstanding load, the buffered ALU entry and the port.
  always_comb begin
    hazard = src_hit(rs1, state_r == LD_WAIT, ld_rd_r, buf_valid_r, buf_rd_r,
                     write, wrAddr) ||
             src_hit(rs2, state_r == LD_WAIT, ld_rd_r, buf_valid_r, buf_rd_r,
                     write, wrAddr);
  end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Scoreboard bench for load_writeback_unit: expected writes are queued when
// stimulus is driven and matched (address, data, cycle) when write pulses.
module tb_load_writeback_unit;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_ready;
  logic        ld_req;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        ld_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard;
  logic        write;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc;
  int   n_vec;
  int   n_err;

  load_writeback_unit dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_result (alu_result),
    .alu_ready  (alu_ready),
    .ld_req     (ld_req),
    .ld_rd      (ld_rd),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .ld_ready   (ld_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rs1        (rs1),
    .rs2        (rs2),
    .hazard     (hazard),
    .write      (write),
    .wrAddr     (wrAddr),
    .wrData     (wrData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected writes.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid  = 1'b0;
    alu_rd     = 5'd0;
    alu_result = 32'h0;
    ld_req     = 1'b0;
    ld_rd      = 5'd0;
    ld_funct3  = 3'd0;
    ld_addr_lo = 2'd0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input int at);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = at;
    sb_q.push_back(e);
  endtask

  // Monitor: every write pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1 && write === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("write_unexpected", {31'd0, write}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("wr_addr", {27'd0, wrAddr}, {27'd0, e.addr});
        chk("wr_data", wrData, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  // Full load: request, data the next cycle, idle cycle to observe ld_ready.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] raw, input logic [31:0] exp_data);
    step();
    idle_inputs();
    ld_req = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = lo;
    @(negedge clk);
    chk("ld_ready_idle", {31'd0, ld_ready}, 32'd1);
    step();
    idle_inputs();
    mem_rvalid = 1'b1; mem_rdata = raw;
    if (rd != 5'd0) expect_wr(rd, exp_data, cyc + 1);
    @(negedge clk);
    chk("ld_ready_wait", {31'd0, ld_ready}, 32'd0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("ld_ready_back", {31'd0, ld_ready}, 32'd1);
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic [31:0] d);
    step();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = rd; alu_result = d;
    if (rd != 5'd0) expect_wr(rd, d, cyc + 1);
    @(negedge clk);
    chk("alu_ready", {31'd0, alu_ready}, 32'd1);
    step();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc = 0; n_vec = 0; n_err = 0;
    idle_inputs();
    rs1 = 5'd0; rs2 = 5'd0;
    reset = 1'b0;
    #2;
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_wraddr", {27'd0, wrAddr}, 32'd0);
    chk("rst_wrdata", wrData, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst_hazard", {31'd0, hazard}, 32'd0);
    step(); step();
    reset = 1'b1;
    step();

    // Load alignment and extension
    do_load(5'd5,  3'b000, 2'd3, 32'h80FF_1234, 32'hFFFF_FF80);
    do_load(5'd6,  3'b101, 2'd2, 32'hBEEF_0001, 32'h0000_BEEF);
    do_load(5'd6,  3'b001, 2'd2, 32'hBEEF_0001, 32'hFFFF_BEEF);
    do_load(5'd4,  3'b010, 2'd1, 32'hBEEF_0001, 32'hBEEF_0001);
    do_load(5'd1,  3'b000, 2'd0, 32'h1234_567F, 32'h0000_007F);
    do_load(5'd2,  3'b100, 2'd3, 32'h80FF_1234, 32'h0000_0080);
    do_load(5'd3,  3'b001, 2'd3, 32'hBEEF_0001, 32'hFFFF_BEEF);
    do_load(5'd20, 3'b011, 2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D);
    do_load(5'd21, 3'b101, 2'd0, 32'hBEEF_8001, 32'h0000_8001);
    do_load(5'd22, 3'b001, 2'd1, 32'hBEEF_8001, 32'hFFFF_8001);

    // ALU path including x0
    do_alu(5'd3, 32'hDEAD_BEEF);
    do_alu(5'd0, 32'h1234_5678);
    do_alu(5'd31, 32'h0000_0001);

    // Collision: load completion and ALU result in the same cycle
    step(); idle_inputs();
    ld_req = 1'b1; ld_rd = 5'd8; ld_funct3 = 3'b010;
    step(); idle_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_result = 32'h11;
    expect_wr(5'd8, 32'h1234_5678, cyc + 1);
    expect_wr(5'd7, 32'h0000_0011, cyc + 2);
    @(negedge clk);
    chk("coll_alu_ready_m", {31'd0, alu_ready}, 32'd1);
    step(); idle_inputs();
    rs1 = 5'd7;
    @(negedge clk);
    chk("coll_alu_ready_m1", {31'd0, alu_ready}, 32'd0);
    chk("buf_hazard", {31'd0, hazard}, 32'd1);
    step(); idle_inputs();
    rs1 = 5'd0;
    @(negedge clk);
    chk("coll_alu_ready_m2", {31'd0, alu_ready}, 32'd1);
    step(); idle_inputs();

    // Hazard on an outstanding load
    step(); idle_inputs();
    ld_req = 1'b1; ld_rd = 5'd9; ld_funct3 = 3'b010; rs1 = 5'd9;
    @(negedge clk);
    chk("haz_idle", {31'd0, hazard}, 32'd0);
    step(); idle_inputs();
    @(negedge clk);
    chk("haz_wait1", {31'd0, hazard}, 32'd1);
    step(); idle_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0009;
    expect_wr(5'd9, 32'hA5A5_0009, cyc + 1);
    @(negedge clk);
    chk("haz_wait2", {31'd0, hazard}, 32'd1);
    step(); idle_inputs();
    @(negedge clk);
    chk("haz_write", {31'd0, hazard}, 32'd1);
    step(); idle_inputs();
    @(negedge clk);
    chk("haz_after", {31'd0, hazard}, 32'd0);
    rs1 = 5'd0;

    // Load to x0 with rs2=0: no hazard and no write
    step(); idle_inputs();
    ld_req = 1'b1; ld_rd = 5'd0; rs2 = 5'd0;
    step(); idle_inputs();
    @(negedge clk);
    chk("x0_hazard", {31'd0, hazard}, 32'd0);
    chk("x0_ld_ready", {31'd0, ld_ready}, 32'd0);
    step(); idle_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step(); idle_inputs();
    @(negedge clk);
    chk("x0_fsm_idle", {31'd0, ld_ready}, 32'd1);

    // Back-to-back loads at the earliest cycles
    step(); idle_inputs();
    ld_req = 1'b1; ld_rd = 5'd12; ld_funct3 = 3'b010;
    step(); idle_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    expect_wr(5'd12, 32'h0BAD_F00D, cyc + 1);
    step(); idle_inputs();
    ld_req = 1'b1; ld_rd = 5'd13; ld_funct3 = 3'b100; ld_addr_lo = 2'd1;
    @(negedge clk);
    chk("b2b_ld_ready", {31'd0, ld_ready}, 32'd1);
    step(); idle_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_9A00;
    expect_wr(5'd13, 32'h0000_009A, cyc + 1);
    step(); idle_inputs();
    step();

    // Reset in WAIT aborts the load
    step(); idle_inputs();
    ld_req = 1'b1; ld_rd = 5'd14; ld_funct3 = 3'b010;
    step(); idle_inputs();
    reset = 1'b0;
    #1;
    chk("rst_async_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_async_wraddr", {27'd0, wrAddr}, 32'd0);
    step();
    reset = 1'b1;
    step(); idle_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    step(); idle_inputs();
    rs1 = 5'd14;
    @(negedge clk);
    chk("rst_mid_write", {31'd0, write}, 32'd0);
    chk("rst_mid_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_mid_wrdata", wrData, 32'd0);
    chk("rst_mid_wraddr", {27'd0, wrAddr}, 32'd0);
    chk("rst_mid_hazard", {31'd0, hazard}, 32'd0);
    rs1 = 5'd0;
    step(); step();

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
